// File: rtl/audio_sample_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_sample_feeder                                                      |
// | Sample FIFO replayed at 2^DIV_LOG2-clock intervals into the sigma-delta |
// | DAC; define AUDIO_INTERP_EN for linear interpolation, else zero-order   |
// | hold.                                                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module audio_sample_feeder #(
  parameter int DIV_LOG2   = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_res,
  input  logic [15:0]           i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [15:0]           o_data,
  output logic                  o_tick,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underrun,
  input  logic                  i_clr_underrun
);

  localparam int                    c_depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   c_lvl_one   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DIV_LOG2-1:0]   c_phase_one = {{(DIV_LOG2-1){1'b0}}, 1'b1};

  logic [15:0]           r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DIV_LOG2-1:0]   r_phase;
  logic                  r_underrun;
  logic [15:0]           r_data;

  logic                  w_tick;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_pop;
  logic [15:0]           w_head;

  assign w_tick  = &r_phase;
  assign w_empty = (r_level == '0);
  assign w_wr    = i_valid && (r_level != c_full);
  assign w_pop   = w_tick && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + c_phase_one;
    end
  end

  // Storage has no reset: an empty level makes any stale contents unreachable.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

  // A fresh underrun takes priority over a simultaneous clear request.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_underrun <= 1'b0;
    end else if (w_tick && w_empty) begin
      r_underrun <= 1'b1;
    end else if (i_clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

`ifdef AUDIO_INTERP_EN
  localparam int c_acc_w = 17 + DIV_LOG2;

  logic [15:0]         r_cur;
  logic [16:0]         r_diff;
  logic [c_acc_w-1:0]  r_acc;
  logic [c_acc_w-1:0]  w_cur_base;
  logic [c_acc_w-1:0]  w_diff_ext;
  logic [16:0]         w_step;

  // acc walks from prev<<L toward cur<<L, so the sliced output never overflows.
  assign w_cur_base = {r_cur[15], r_cur, {DIV_LOG2{1'b0}}};
  assign w_diff_ext = {{DIV_LOG2{r_diff[16]}}, r_diff};
  assign w_step     = {w_head[15], w_head} - {r_cur[15], r_cur};

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_cur  <= '0;
      r_diff <= '0;
      r_acc  <= '0;
      r_data <= '0;
    end else begin
      r_data <= r_acc[DIV_LOG2+15:DIV_LOG2];
      if (w_tick) begin
        r_acc <= w_cur_base;
        if (w_pop) begin
          r_diff <= w_step;
          r_cur  <= w_head;
        end else begin
          r_diff <= '0;
        end
      end else begin
        r_acc <= r_acc + w_diff_ext;
      end
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_data <= '0;
    end else if (w_pop) begin
      r_data <= w_head;
    end
  end
`endif

  assign o_ready    = (r_level != c_full);
  assign o_level    = r_level;
  assign o_tick     = w_tick;
  assign o_data     = r_data;
  assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_feeder.sv
`default_nettype none
// Bench for audio_sample_feeder: directed fill/underrun pins plus randomized
// traffic against a queue-based reference model.
module tb_audio_sample_feeder;

  localparam int L     = 2;
  localparam int D     = 2;
  localparam int P     = 1 << L;
  localparam int DEPTH = 1 << D;

  logic        i_clk          = 1'b0;
  logic        i_res          = 1'b1;
  logic [15:0] i_data         = '0;
  logic        i_valid        = 1'b0;
  logic        i_clr_underrun = 1'b0;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_tick;
  logic [D:0]  o_level;
  logic        o_underrun;

  audio_sample_feeder #(.DIV_LOG2(L), .DEPTH_LOG2(D)) u_dut (
    .i_clk          (i_clk),
    .i_res          (i_res),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_tick         (o_tick),
    .o_level        (o_level),
    .o_underrun     (o_underrun),
    .i_clr_underrun (i_clr_underrun)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sample queue, cycle count since reset release, and the
  // current interpolation segment acc(c) = base*P + d*(c - s).
  logic [15:0] q[$];
  int          m_cyc   = 0;
  int          m_base  = 0;
  int          m_d     = 0;
  int          m_s     = 0;
  int          m_cur   = 0;
  logic [15:0] m_data  = '0;
  bit          m_under = 1'b0;

  always @(posedge i_clk or negedge i_res) begin
    bit tick;
    bit pop;
    bit wr;
    int head;
    if (!i_res) begin
      q.delete();
      m_cyc = 0; m_base = 0; m_d = 0; m_s = 0; m_cur = 0;
      m_data = '0; m_under = 1'b0;
    end else begin
      tick = (m_cyc % P) == P - 1;
      pop  = tick && (q.size() != 0);
      wr   = i_valid && (q.size() != DEPTH);
      head = 0;
`ifdef AUDIO_INTERP_EN
      m_data = 16'((m_base * P + m_d * (m_cyc - m_s)) >>> L);
`endif
      if (tick) begin
        if (pop) head = $signed(q.pop_front());
`ifdef AUDIO_INTERP_EN
        m_base = m_cur;
        m_d    = pop ? head - m_cur : 0;
        m_s    = m_cyc + 1;
        if (pop) m_cur = head;
`else
        if (pop) m_data = 16'(head);
`endif
      end
      if (tick && !pop) m_under = 1'b1;
      else if (i_clr_underrun) m_under = 1'b0;
      if (wr) q.push_back(i_data);
      m_cyc++;
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("level",    int'(o_level),    q.size());
      check("ready",    int'(o_ready),    int'(q.size() != DEPTH));
      check("tick",     int'(o_tick),     int'((m_cyc % P) == P - 1));
      check("data",     int'(o_data),     int'(m_data));
      check("underrun", int'(o_underrun), int'(m_under));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int probs[3];
    probs = '{90, 25, 55};
    #3 i_res = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_res = 1'b1;

    // Directed: underrun at first tick, clear, fill to full, stall on 0x0600.
    for (int k = 0; k < 14; k++) begin
      i_valid        = (k >= 4) && (k <= 12);
      i_data         = (k <= 8) ? 16'((k - 3) * 256) : 16'h0600;
      i_clr_underrun = (k == 5);
      case (k)
        0: begin
          check("rst_level", int'(o_level), 0);
          check("rst_ready", int'(o_ready), 1);
          check("rst_data",  int'(o_data),  0);
          check("rst_tick",  int'(o_tick),  0);
        end
        2: check("tick_c2", int'(o_tick), 0);
        3: check("tick_c3", int'(o_tick), 1);
        4: check("under_set", int'(o_underrun), 1);
        6: check("under_clr", int'(o_underrun), 0);
        7: begin
          check("lvl_c7",  int'(o_level), 3);
          check("data_c7", int'(o_data),  0);
        end
        9: begin
          check("full_level", int'(o_level), 4);
          check("full_ready", int'(o_ready), 0);
        end
        12: begin
          check("drain_level", int'(o_level), 3);
          check("drain_ready", int'(o_ready), 1);
        end
        13: check("refill_level", int'(o_level), 4);
        default: ;
      endcase
`ifdef AUDIO_INTERP_EN
      case (k)
        9:  check("ramp0", int'(o_data), 16'h0000);
        10: check("ramp1", int'(o_data), 16'h0040);
        11: check("ramp2", int'(o_data), 16'h0080);
        12: check("ramp3", int'(o_data), 16'h00C0);
        13: check("ramp4", int'(o_data), 16'h0100);
        default: ;
      endcase
`else
      if (k == 8)  check("zoh_first",  int'(o_data), 16'h0100);
      if (k == 12) check("zoh_second", int'(o_data), 16'h0200);
`endif
      step();
    end

    for (int ph = 0; ph < 3; ph++) begin
      repeat (500) begin
        i_valid        = ($urandom % 100) < probs[ph];
        i_data         = pick();
        i_clr_underrun = ($urandom % 8) == 0;
        step();
      end
    end

    // Mid-stream asynchronous reset with a partly filled FIFO.
    i_clr_underrun = 1'b0;
    repeat (6) begin
      i_valid = 1'b1;
      i_data  = pick();
      step();
    end
    i_valid = 1'b0;
    #2 i_res = 1'b0;
    #1;
    check("async_level", int'(o_level), 0);
    check("async_data",  int'(o_data),  0);
    check("async_ready", int'(o_ready), 1);
    @(posedge i_clk);
    #1 i_res = 1'b1;
    step();
    step();
    check("rel_tick_c2", int'(o_tick), 0);
    step();
    check("rel_tick_c3", int'(o_tick), 1);

    repeat (400) begin
      i_valid        = ($urandom % 100) < 60;
      i_data         = pick();
      i_clr_underrun = ($urandom % 6) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
